// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit 7-segment scan display: segment table,
// all-off constants and the scan FSM state type.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {dp, g, f, e, d, c, b, a}; dp is left off in every entry
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        SHOW,
        GAP
    } state_t;

endpackage

// File: rtl/seg7_scan_display_if.sv
// Debug-word bus feeding the scan display: data word, capture strobe,
// blanking and decimal-point mask.
interface seg7_scan_display_if;

    logic [31:0] data_in;
    logic        data_valid;
    logic        blank;
    logic [7:0]  dp_mask;

    modport master (output data_in, data_valid, blank, dp_mask);
    modport slave  (input  data_in, data_valid, blank, dp_mask);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [7:0] entry;

    always_comb begin
        entry = HEX_SEG[nibble];
        seg   = entry[6:0];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with all-off gaps.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_DIV_W  = 17,
    parameter int GAP_CYCLES = 4,
    parameter int DIGITS     = 8
)
(
    input  logic                       clk,
    input  logic                       rst,
    seg7_scan_display_if.slave         bus,
    output logic [DIGITS-1:0]          AN,
    output logic [7:0]                 SEG,
    output logic [$clog2(DIGITS)-1:0]  digit_idx
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W = (CLK_DIV_W > GAP_W) ? CLK_DIV_W : GAP_W;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'((64'd1 << CLK_DIV_W) - 64'd1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]     shadow_q;
    logic [DIGITS-1:0]       an_d;
    logic [7:0]              seg_d;
    logic [3:0]              nibble;
    logic [6:0]              seg_hex;
    logic                    lz_hide;

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (seg_hex)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SHOW;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            AN       <= AN_OFF;
            SEG      <= SEG_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            AN      <= an_d;
            SEG     <= seg_d;
            if (bus.data_valid) begin
                shadow_q <= bus.data_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = SHOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage works from the current shadow, so a mid-digit strobe
    // shows up one cycle after capture without disturbing the scan timing.
    always_comb begin
        nibble = shadow_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lz_hide = (idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == '0);
`else
        lz_hide = 1'b0;
`endif
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if ((state_q == SHOW) && !bus.blank && !lz_hide) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = {~bus.dp_mask[idx_q], seg_hex};
        end
    end

    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display at CLK_DIV_W=3, GAP_CYCLES=2 (10-cycle digit period).
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] AN;
    logic [7:0] SEG;
    logic [2:0] digit_idx;
    int         cyc;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] seg;
        bit         chk_idx;
        logic [2:0] idx;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    seg7_scan_display_if bif ();

    seg7_scan_display #(
        .CLK_DIV_W  (3),
        .GAP_CYCLES (2),
        .DIGITS     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .bus       (bif),
        .AN        (AN),
        .SEG       (SEG),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    // Edge counter: value N after the N-th clock edge since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push(input int c, input logic [7:0] an, input logic [7:0] seg, input string nm);
        exp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.chk_idx = 1'b0; e.idx = '0; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic push_idx(input int c, input logic [7:0] an, input logic [7:0] seg,
                            input logic [2:0] idx, input string nm);
        exp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.chk_idx = 1'b1; e.idx = idx; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic wait_to(input int n);
        int guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        tests++;
        if (cyc != n) begin
            fails++;
            $display("FAIL wait_to: cycle %0d required %0d", cyc, n);
        end
    endtask

    // Monitor: every cycle the DUT presents AN/SEG; compare entries due now
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                tests++;
                if (e.cyc < cyc) begin
                    fails++;
                    $display("FAIL %s: missed at cycle %0d required cycle %0d", e.name, cyc, e.cyc);
                end else if (AN !== e.an || SEG !== e.seg ||
                             (e.chk_idx && digit_idx !== e.idx)) begin
                    fails++;
                    $display("FAIL %s @%0d: AN=%h SEG=%h idx=%0d required AN=%h SEG=%h idx=%0d",
                             e.name, cyc, AN, SEG, digit_idx, e.an, e.seg, e.idx);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bif.data_in    = '0;
        bif.data_valid = 1'b0;
        bif.blank      = 1'b0;
        bif.dp_mask    = '0;

        #11;
        check8("rst_an",  AN,  8'hFF);
        check8("rst_seg", SEG, 8'hFF);
        check8("rst_idx", {5'b0, digit_idx}, 8'h00);

        // Free-running scan of an all-zero word
        push_idx(1,  8'hFE, 8'hC0, 3'd0, "d0_first");
        push(8,      8'hFE, 8'hC0, "d0_last");
        push(9,      8'hFF, 8'hFF, "gap0_a");
        push_idx(10, 8'hFF, 8'hFF, 3'd1, "gap0_b");
        push(11,     8'hFD, 8'hC0, "d1_first");
        push_idx(79, 8'hFF, 8'hFF, 3'd7, "gap7");
        push_idx(80, 8'hFF, 8'hFF, 3'd0, "wrap_idx");
        #1 rst_n = 1'b1;

        // Strobe 89ABCDEF with dp on digit 0
        wait_to(80);
        push(81,     8'hFE, 8'h40, "dp_old_shadow");
        push(82,     8'hFE, 8'h0E, "d0_F_dp");
        push(88,     8'hFE, 8'h0E, "d0_F_dp_end");
        push(91,     8'hFD, 8'h86, "d1_E");
        push(101,    8'hFB, 8'hA1, "d2_d");
        push(151,    8'h7F, 8'h80, "d7_8");
        push_idx(160, 8'hFF, 8'hFF, 3'd0, "wrap2");
        push(161,    8'hFE, 8'h0E, "d0_again");
        bif.data_in    = 32'h89ABCDEF;
        bif.data_valid = 1'b1;
        bif.dp_mask    = 8'h01;
        wait_to(81);
        bif.data_valid = 1'b0;

        // Mid-digit strobe of 00000005 during digit 0
        wait_to(161);
        push(162,    8'hFE, 8'h8E, "mid_before");
        push(164,    8'hFE, 8'h8E, "mid_strobe_edge");
        push(165,    8'hFE, 8'h92, "mid_after");
        push(168,    8'hFE, 8'h92, "mid_last");
        push(169,    8'hFF, 8'hFF, "mid_gap");
        push(171,    8'hFD, 8'hC0, "mid_next");
        bif.dp_mask = 8'h00;
        wait_to(163);
        bif.data_in    = 32'h00000005;
        bif.data_valid = 1'b1;
        wait_to(164);
        bif.data_valid = 1'b0;

        // Blank for 3 cycles during digit 1
        wait_to(171);
        push(172,    8'hFD, 8'hC0, "blk_before");
        push(173,    8'hFF, 8'hFF, "blk_first");
        push(175,    8'hFF, 8'hFF, "blk_last");
        push(176,    8'hFD, 8'hC0, "blk_after");
        push(178,    8'hFD, 8'hC0, "blk_d1_end");
        push(179,    8'hFF, 8'hFF, "blk_gap");
        push(181,    8'hFB, 8'hC0, "blk_d2_start");
        wait_to(172);
        bif.blank = 1'b1;
        wait_to(175);
        bif.blank = 1'b0;

        // Async reset during the gap after digit 5
        wait_to(181);
        push(211,     8'hDF, 8'hC0, "d5_first");
        push_idx(218, 8'hDF, 8'hC0, 3'd5, "d5_last");
        wait_to(218);
        #4;
        rst_n = 1'b0;
        #1;
        check8("async_an",  AN,  8'hFF);
        check8("async_seg", SEG, 8'hFF);
        check8("async_idx", {5'b0, digit_idx}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #3;
        check8("held_an", AN, 8'hFF);
        rst_n = 1'b1;

        // Restart from digit 0, then a word with leading zeros
        push_idx(1, 8'hFE, 8'hC0, 3'd0, "restart_d0");
        push(2,     8'hFE, 8'hC0, "lz_d0_old");
        push(11,    8'hFD, 8'hB0, "lz_d1_3");
        push(18,    8'hFD, 8'hB0, "lz_d1_end");
        push(21,    8'hFB, 8'h88, "lz_d2_A");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        push(31,    8'hFF, 8'hFF, "lz_d3_hidden");
        push(71,    8'hFF, 8'hFF, "lz_d7_hidden");
`else
        push(31,    8'hF7, 8'hC0, "lz_d3_shown");
        push(71,    8'h7F, 8'hC0, "lz_d7_shown");
`endif
        push_idx(80, 8'hFF, 8'hFF, 3'd0, "lz_wrap");
        push(81,    8'hFE, 8'hC0, "zero_d0");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        push(91,    8'hFF, 8'hFF, "zero_d1_hidden");
        push(101,   8'hFF, 8'hFF, "zero_d2_hidden");
`else
        push(91,    8'hFD, 8'hC0, "zero_d1_shown");
        push(101,   8'hFB, 8'hC0, "zero_d2_shown");
`endif
        wait_to(1);
        bif.data_in    = 32'h00000A30;
        bif.data_valid = 1'b1;
        wait_to(2);
        bif.data_valid = 1'b0;
        wait_to(77);
        bif.data_in    = 32'h00000000;
        bif.data_valid = 1'b1;
        wait_to(78);
        bif.data_valid = 1'b0;

        wait_to(102);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the 32-bit debug word the data route selects (register, RAM word, PC or cycle count) for the board's 8-digit common-anode 7-segment display.
- Captures the word on a strobe and time-multiplexes it as 8 hex digits.
- Inserts an all-off gap between digits to prevent ghosting.
- Drives AN/SEG pins directly, replacing the ad-hoc scan logic inside the data route.

Parameters:
- CLK_DIV_W, 17, width of refresh counter; each digit is lit for 2^CLK_DIV_W cycles.
- GAP_CYCLES, 4, cycles with all anodes off between digits; must be ≥1.
- DIGITS, 8, number of digits scanned; fixed at 8 for this board.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- data_in  in  32  word to display; nibble k goes to digit k (digit 0 = rightmost)
- data_valid  in  1  when high at a clk edge, data_in is captured into shadow register
- blank  in  1  when high, all anodes off; scan keeps running
- dp_mask  in  8  bit k=1 lights decimal point of digit k
- AN  out  8  anode enables, active-low
- SEG  out  8  active-low; SEG[6:0]=gfedcba, SEG[7]=dp
- digit_idx  out  3  index of the digit currently lit or next to be lit

Behaviour:
- Reset (rst=0, async): AN=8'hFF, SEG=8'hFF, digit_idx=0, shadow=0, refresh counter=0, state=SHOW.
- Shadow register:
  - Loaded on any clk edge with data_valid=1; a new value becomes visible on SEG one cycle later.
  - A mid-digit update changes the lit digit's segments without restarting the scan.
  - Back-to-back strobes: last one wins.
- FSM states SHOW and GAP:
  - SHOW: counter increments each cycle. When counter == 2^CLK_DIV_W-1, go to GAP and clear the counter.
  - GAP: counter increments. When counter == GAP_CYCLES-1, clear the counter, set digit_idx = (digit_idx+1) mod 8, go to SHOW.
  - digit_idx wraps 7→0.
- Outputs are registered (1-cycle latency from state, digit_idx, shadow, blank, dp_mask):
  - In SHOW with blank=0: AN = ~(1<<digit_idx); SEG[6:0] = hex decode of shadow[4*digit_idx+:4]; SEG[7] = ~dp_mask[digit_idx].
  - In GAP, or with blank=1: AN=8'hFF, SEG=8'hFF.
- Hex decode, active-low gfedcba:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- blank asserted mid-digit blanks outputs next cycle; counter and FSM are unaffected.
- Reset asserted mid-scan returns everything to reset values immediately. After release, the first SHOW of digit 0 begins on the first clk edge.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 whose nibble and all higher nibbles of shadow are zero is shown with AN bit off and SEG=8'hFF. Scan timing is unchanged. Digit 0 is always shown, so shadow=0 displays a single "0".
- Undefined: all 8 digits always shown, including leading zeros.

Decomposition:
- Shared package seg7_pkg holds:
  - 16-entry hex-to-segment constant table
  - SEG_OFF=8'hFF and AN_OFF=8'hFF constants
  - FSM state typedef {SHOW, GAP}
- One natural sub-module: seg7_hex_decode (combinational, 4-bit nibble in, 7-bit active-low segments out), instantiated once on the muxed nibble.

Test Plan (CLK_DIV_W=3, GAP_CYCLES=2 → 10-cycle digit period):
- Reset release, data_valid=0 → AN=FE, SEG=C0 for 8 cycles, then AN=FF for 2 cycles, then AN=FD; digit_idx steps 0..7 and wraps to 0 after 80 cycles.
- Strobe data_in=32'h89ABCDEF, dp_mask=8'h01 → digit 0 shows SEG=0E (F plus dp), digit 1 SEG=86, digit 7 SEG=80; AN follows FE, FD, ..., 7F.
- Mid-digit strobe data_in=32'h00000005 during digit 0 SHOW → SEG changes from prior value to 92 exactly one cycle after the strobe; AN unchanged and counter not restarted.
- blank=1 for 3 cycles during SHOW → AN=FF and SEG=FF for those 3 cycles plus 1-cycle latency; next digit starts at the same cycle as without blank.
- Async rst=0 mid-GAP of digit 5 → AN=FF, SEG=FF, digit_idx=0 with no clk edge; after release, scan restarts from digit 0.
- SEG7_LEADING_ZERO_BLANK_EN defined, shadow=32'h00000A30 → digits 0-2 lit (SEG C0, B0, 88); digits 3-7 AN bit off; shadow=0 → only digit 0 lit showing C0.
